// File: rtl/riscv_pkg.sv
// Shared core definitions: arbiter FSM states, requester IDs, counter width.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Requester identifiers, also the encoding of the last-grant register.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Access-cycle counter width; bounds LAT to 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break for the memory arbiter.
// MEM_ARB_RR_EN defined: ties alternate, going to the requester not granted last.
// MEM_ARB_RR_EN undefined: ties always go to the data path.
module mem_arb_pick
    import riscv_pkg::*;
(
    output logic winner,
    input  logic if_req,
    input  logic d_req
`ifdef MEM_ARB_RR_EN
    ,
    input  logic last_gnt
`endif
);

    // Single requester always wins; only a tie consults the policy.
    always_comb begin
        winner = d_req ? REQ_D : REQ_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            winner = (last_gnt == REQ_D) ? REQ_IF : REQ_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory2c port between instruction fetch and load/store.
// One transaction at a time: grant in IDLE, LAT cycles of ACCESS, one-cycle
// acknowledge in DONE. Optional round-robin tie-break under MEM_ARB_RR_EN.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_enable,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_lat_check
            $error("mem_arbiter: LAT must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_q, win_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;
    logic             winner;

`ifdef MEM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    mem_arb_pick u_pick (
        .winner   (winner),
        .if_req   (if_req),
        .d_req    (d_req)
`ifdef MEM_ARB_RR_EN
        ,
        .last_gnt (last_q)
`endif
    );

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Next-state and output decode; memory bus is zero outside ACCESS.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                // Gating with rst keeps grants low while reset is held.
                if (rst && (if_req || d_req)) begin
                    if_gnt  = (winner == REQ_IF);
                    d_gnt   = (winner == REQ_D);
                    win_d   = winner;
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_d  = winner;
`endif
                    if (winner == REQ_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wr_d    = d_wr;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                if (cnt_q == '0) begin
                    // Final access cycle: the only write edge of a store.
                    mem_wr  = wr_q;
                    state_d = DONE;
                    if (win_q == REQ_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if_ack  = (win_q == REQ_IF);
                d_ack   = (win_q == REQ_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= REQ_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last-grant register; resets to fetch so the first tie goes to data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= REQ_IF;
        else      last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter at LAT=3 with a behavioural memory2c model.
module tb_mem_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] A = 32'hDEADBEEF;
    localparam logic [31:0] B = 32'h12345678;
    localparam logic [31:0] C = 32'hCAFEF00D;
    localparam logic [31:0] E = 32'h11111111;
    // if_rdata after the tie phase depends on the tie policy.
    localparam logic [31:0] X1 = RR ? A : C;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_gnt, if_ack, d_gnt, d_ack, mem_enable, mem_wr;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    // memory2c model: combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_dat;
        else if (mem_enable && mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [69:0] exp;   // {if_gnt,d_gnt,mem_enable,mem_wr,if_ack,d_ack,if_rdata,d_rdata}
    } vec_t;

    vec_t tbl[$];
    int   vecs = 0;
    int   errs = 0;

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd,
                       input logic ig, input logic dg, input logic en, input logic wr,
                       input logic ik, input logic dk, input logic [31:0] ird, input logic [31:0] drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.exp = {ig, dg, en, wr, ik, dk, ird, drd};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dd;
    endtask

    initial begin
        int n;

        // Cycle-by-cycle table; columns: ir ia dr dw da dd | ig dg en wr ik dk ird drd
        // Fetch 0x10, LAT cycles of access, ack with DEADBEEF.
        add(1, 'h10, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0, A, 0);
        // Store 0x12345678 to 0x40: single write strobe in last access cycle.
        add(0, 0, 1, 1, 'h40, B,          0, 1, 0, 0, 0, 0, A, 0);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, A, 0);
        add(0, 0, 0, 0, 0, 0,             0, 0, 1, 1, 0, 0, A, 0);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 1, A, 0);
        // Fetch 0x40 reads the stored word.
        add(1, 'h40, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, A, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, A, 0);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0, B, 0);
        // Load 0x10; fetch 0x20 arrives mid-access and waits for the next IDLE.
        add(0, 0, 1, 0, 'h10, 0,          0, 1, 0, 0, 0, 0, B, 0);
        for (int k = 0; k < 3; k++) add(1, 'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, B, 0);
        add(1, 'h20, 0, 0, 0, 0,          0, 0, 0, 0, 0, 1, B, A);
        add(1, 'h20, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, B, A);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, B, A);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0, C, A);
        // Both requesting continuously: D first, then policy-dependent.
        add(1, 'h10, 1, 0, 'h20, 0,       0, 1, 0, 0, 0, 0, C, A);
        for (int k = 0; k < 3; k++) add(1, 'h10, 1, 0, 'h20, 0, 0, 0, 1, 0, 0, 0, C, A);
        add(1, 'h10, 1, 0, 'h20, 0,       0, 0, 0, 0, 0, 1, C, C);
        add(1, 'h10, 1, 0, 'h20, 0,       RR, !RR, 0, 0, 0, 0, C, C);
        for (int k = 0; k < 3; k++) add(1, 'h10, 1, 0, 'h20, 0, 0, 0, 1, 0, 0, 0, C, C);
        add(1, 'h10, 1, 0, 'h20, 0,       0, 0, 0, 0, RR, !RR, X1, C);
        add(1, 'h10, 1, 0, 'h20, 0,       0, 1, 0, 0, 0, 0, X1, C);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, X1, C);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 1, X1, C);
        add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, X1, C);

        // Reset held with both requests high; preload memory meanwhile.
        drive(1, 'h10, 1, 0, 'h20, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pre_we  = 1'b1;
            pre_idx = (k == 0) ? 6'd4 : (k == 1) ? 6'd8 : 6'd12;
            pre_dat = (k == 0) ? A : (k == 1) ? C : E;
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk("reset_ctl", {if_gnt, d_gnt, mem_enable, mem_wr, if_ack, d_ack}, '0);
        chk("reset_bus", {mem_addr, mem_wdata, if_rdata, d_rdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            #1;
            chk($sformatf("vec%0d", i),
                {if_gnt, d_gnt, mem_enable, mem_wr, if_ack, d_ack, if_rdata, d_rdata}, tbl[i].exp);
        end

        // Reset in the middle of a store's access phase: no write, no ack.
        @(negedge clk);
        drive(0, 0, 1, 1, 'h30, 32'h55AA55AA);
        #1;
        chk("mid_st_gnt", {if_gnt, d_gnt}, 2'b01);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_st_acc1", {mem_enable, mem_wr, mem_addr}, {2'b10, 32'h30});
        @(negedge clk);
        #1;
        chk("mid_st_acc2", {mem_enable, mem_wr, mem_wdata}, {2'b10, 32'h55AA55AA});
        rst = 1'b0;
        drive(1, 'h30, 0, 0, 0, 0);
        #1;
        chk("mid_rst_ctl", {if_gnt, d_gnt, mem_enable, mem_wr, if_ack, d_ack}, '0);
        chk("mid_rst_bus", {mem_addr, mem_wdata}, '0);
        chk("mid_rst_rdata", {if_rdata, d_rdata}, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_rst_hold", {if_gnt, if_ack, d_ack}, '0);
        chk("mid_rst_mem", mem[12], E);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_gnt", {if_gnt, d_gnt}, 2'b10);
        n = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if_req = 1'b0;
            #1;
            if (if_ack) begin
                n = k;
                break;
            end
        end
        chk("post_ack_cycle", n, LAT + 1);
        chk("post_rdata", if_rdata, E);

        // Tie right after reset goes to data under either policy.
        @(negedge clk);
        drive(1, 'h10, 1, 0, 'h10, 0);
        #1;
        chk("tie_after_rst", {if_gnt, d_gnt}, 2'b01);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        repeat (LAT + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
